dpi_stream_sequencer: RTL

- Upstream feeder for the per-regex cancid matcher wrappers.
- Accepts a byte-wide packet stream tagged with a flow tag and maps the flow to a 6-bit stream_id through a 64-entry direct-mapped flow table.
- Drives the matcher control sequence: load_state, new_stream_id, enable, stream_id, char_in/char_in_vld, and a delayed eop. The sequence is spaced so that state restore completes before the first character and the last accept lands before eop.

---
 rtl/dpi_stream_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/dpi_stream_sequencer.sv
// Purpose: maps a flow-tagged byte stream onto a 64-entry flow table and drives the matcher control sequence.
// Latency: sop -> load_state 2 cycles, load_state -> first char LOAD_GAP+1, last char -> eop EOP_GAP+1, data beats 1 cycle.
// Backpressure: in_ready only for a sop beat in IDLE and for payload beats in STREAM; held low while restoring/draining.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_vld/in_ready          input handshake; in_sop/in_eop/in_data/in_flow_tag carry the beat
//   cfg_we/cfg_addr/cfg_enable   per-stream enable table write
//   flush                    invalidate the whole flow table (deferred to IDLE)
//   stream_id/new_stream_id/enable   per-packet matcher context, held for the whole packet
//   load_state/char_in/char_in_vld/eop   matcher control sequence
//   pkt_count/miss_count     statistics (wrapping / saturating)
module dpi_stream_sequencer #(
    parameter int TAG_W    = 32,
    parameter int LOAD_GAP = 2,
    parameter int EOP_GAP  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_ready,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [7:0]       in_data,
    input  logic [TAG_W-1:0] in_flow_tag,
    input  logic             cfg_we,
    input  logic [5:0]       cfg_addr,
    input  logic             cfg_enable,
    input  logic             flush,
    output logic [5:0]       stream_id,
    output logic             new_stream_id,
    output logic             load_state,
    output logic             enable,
    output logic [7:0]       char_in,
    output logic             char_in_vld,
    output logic             eop,
    output logic [15:0]      pkt_count,
    output logic [15:0]      miss_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_LOAD,
        ST_WAIT,
        ST_STREAM,
        ST_DRAIN,
        ST_EOP
    } state_t;

    state_t           state;
    logic [63:0]      valid_q;
    logic [63:0]      enable_mem;
    logic [TAG_W-1:0] tag_mem [64];

    logic [TAG_W-1:0] tag_q;
    logic [5:0]       idx_q;
    logic [7:0]       byte_q;      // sop byte, held until the matcher state is restored
    logic             single_q;    // sop beat also carried eop
    logic             eop_taken;   // last byte of the packet has been issued to char_in
    logic             flush_pend;
    logic [7:0]       cnt;

    logic [5:0] sop_idx;
    logic       hit;
    logic       en_lookup;
    logic       flush_now;

    assign sop_idx   = in_flow_tag[5:0] ^ in_flow_tag[11:6];
    assign hit       = valid_q[idx_q] & (tag_mem[idx_q] == tag_q);
    // A table write landing on the LOOKUP cycle must be visible to that lookup.
    assign en_lookup = (cfg_we && (cfg_addr == idx_q)) ? cfg_enable : enable_mem[idx_q];
    // Flush is only applied while idle; it takes priority over a sop in the same cycle.
    assign flush_now = (state == ST_IDLE) & (flush | flush_pend);

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (state == ST_IDLE)
                in_ready = in_vld & in_sop & ~flush_now;
            else if (state == ST_STREAM)
                in_ready = ~eop_taken;
        end
    end

    // Tag storage has no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (!rst && (state == ST_LOOKUP) && !hit)
            tag_mem[idx_q] <= tag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            valid_q       <= '0;
            enable_mem    <= '0;
            tag_q         <= '0;
            idx_q         <= '0;
            byte_q        <= '0;
            single_q      <= 1'b0;
            eop_taken     <= 1'b0;
            flush_pend    <= 1'b0;
            cnt           <= '0;
            stream_id     <= '0;
            new_stream_id <= 1'b0;
            load_state    <= 1'b0;
            enable        <= 1'b0;
            char_in       <= '0;
            char_in_vld   <= 1'b0;
            eop           <= 1'b0;
            pkt_count     <= '0;
            miss_count    <= '0;
        end else begin
            if (cfg_we)
                enable_mem[cfg_addr] <= cfg_enable;

            load_state  <= 1'b0;
            eop         <= 1'b0;
            char_in_vld <= 1'b0;

            if (flush && (state != ST_IDLE))
                flush_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (flush_now) begin
                        valid_q    <= '0;
                        flush_pend <= 1'b0;
                    end else if (in_vld && in_sop) begin
                        tag_q    <= in_flow_tag;
                        idx_q    <= sop_idx;
                        byte_q   <= in_data;
                        single_q <= in_eop;
                        state    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    stream_id     <= idx_q;
                    new_stream_id <= ~hit;
                    enable        <= en_lookup;
                    if (!hit) begin
                        valid_q[idx_q] <= 1'b1;
                        if (miss_count != 16'hFFFF)
                            miss_count <= miss_count + 16'd1;
                    end
                    load_state <= 1'b1;
                    state      <= ST_LOAD;
                end
                ST_LOAD: begin
                    cnt   <= 8'(LOAD_GAP - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == 8'd0) begin
                        char_in     <= byte_q;
                        char_in_vld <= 1'b1;
                        eop_taken   <= single_q;
                        state       <= ST_STREAM;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_STREAM: begin
                    if (eop_taken) begin
                        cnt   <= 8'(EOP_GAP - 1);
                        state <= ST_DRAIN;
                    end else if (in_vld) begin
                        char_in     <= in_data;
                        char_in_vld <= 1'b1;
                        if (in_eop)
                            eop_taken <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == 8'd0) begin
                        eop   <= 1'b1;
                        state <= ST_EOP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_EOP: begin
                    pkt_count <= pkt_count + 16'd1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
